// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the scorekeeper display path: binary score width,
// BCD correction threshold, converter FSM state encoding and a small helper
// used to derive the leading-zero blank flags.
// -----------------------------------------------------------------------------
package score_pkg;

    // Binary score width, shared with the scorekeeper currScore output
    localparam int SCORE_W = 8;

    // A BCD digit at or above this value overflows past 9 when doubled
    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

    // Converter FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True when a BCD digit is zero (drives leading-zero blanking)
    function automatic logic is_zero_digit(input logic [3:0] digit);
        return (digit == 4'd0);
    endfunction

endpackage : score_pkg

// File: rtl/bcd_add3_cell.sv
// -----------------------------------------------------------------------------
// bcd_add3_cell
// Double-dabble correction cell: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
// Purely combinational.
//
// Ports:
//   din   in  4  BCD digit before correction
//   dout  out 4  corrected digit (din + 3 when din >= 5, else din)
// -----------------------------------------------------------------------------
module bcd_add3_cell
    import score_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3 correction
    always_comb begin
        dout = din;
        if (din >= BCD_ADD3_THRESH) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule : bcd_add3_cell

// File: rtl/score_bcd_converter.sv
// -----------------------------------------------------------------------------
// score_bcd_converter
// Converts the binary score into three BCD digits for the seven-segment
// decoders using a sequential shift-add-3 (double-dabble), one bit per clock.
// A conversion starts by itself whenever score_in differs from the value last
// captured; score_in is ignored while a conversion is running, so only the
// most recent value is converted once the FSM returns to IDLE. The digit and
// blank outputs are registered and change together on the final shift edge.
//
// Ports:
//   clk         in  1      system clock, rising edge
//   rst         in  1      asynchronous reset, active low
//   score_in    in  WIDTH  binary score from the scorekeeper
//   ones        out 4      BCD ones digit
//   tens        out 4      BCD tens digit
//   hundreds    out 4      BCD hundreds digit
//   tens_blank  out 1      hundreds and tens both zero
//   hund_blank  out 1      hundreds zero
//   busy        out 1      conversion in progress
//   valid       out 1      digits reflect the last captured value
// -----------------------------------------------------------------------------
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int WIDTH  = SCORE_W,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] score_in,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic             tens_blank,
    output logic             hund_blank,
    output logic             busy,
    output logic             valid
);

    localparam int          BCD_W    = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Registered state
    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   shift_r;
    logic [BCD_W-1:0]   scratch_r;
    logic [WIDTH-1:0]   last_r;

    // Next-state values
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [WIDTH-1:0]   shift_s;
    logic [BCD_W-1:0]   scratch_s;
    logic [WIDTH-1:0]   last_s;
    logic [3:0]         ones_s;
    logic [3:0]         tens_s;
    logic [3:0]         hundreds_s;
    logic               tens_blank_s;
    logic               hund_blank_s;
    logic               busy_s;
    logic               valid_s;

    // Corrected scratch and the combined scratch/shift word after one shift
    logic [BCD_W-1:0]       adj_s;
    logic [BCD_W+WIDTH-1:0] cat_s;

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_add3
            bcd_add3_cell u_add3 (
                .din  (scratch_r[4*d +: 4]),
                .dout (adj_s[4*d +: 4])
            );
        end
    endgenerate

    // Correct first, then shift the whole {scratch, shift} word left by one.
    // The bit shifted out of the top digit is always zero for legal DIGITS.
    assign cat_s = {adj_s, shift_r} << 1;

    // FSM next-state, datapath and output next values
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shift_s      = shift_r;
        scratch_s    = scratch_r;
        last_s       = last_r;
        ones_s       = ones;
        tens_s       = tens;
        hundreds_s   = hundreds;
        tens_blank_s = tens_blank;
        hund_blank_s = hund_blank;
        busy_s       = busy;
        valid_s      = valid;

        case (state_r)
            ST_IDLE: begin
                if (score_in != last_r) begin
                    shift_s   = score_in;
                    last_s    = score_in;
                    scratch_s = {BCD_W{1'b0}};
                    cnt_s     = {CNT_W{1'b0}};
                    busy_s    = 1'b1;
                    valid_s   = 1'b0;
                    state_s   = ST_SHIFT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scratch_s = cat_s[BCD_W+WIDTH-1:WIDTH];
                shift_s   = cat_s[WIDTH-1:0];
                cnt_s     = cnt_r + CNT_W'(1);
                // Last input bit has just been shifted in: publish digits
                if (cnt_r == LAST_CNT) begin
                    ones_s       = cat_s[WIDTH +: 4];
                    tens_s       = cat_s[WIDTH+4 +: 4];
                    hundreds_s   = cat_s[WIDTH+8 +: 4];
                    hund_blank_s = is_zero_digit(cat_s[WIDTH+8 +: 4]);
                    tens_blank_s = is_zero_digit(cat_s[WIDTH+8 +: 4]) &
                                   is_zero_digit(cat_s[WIDTH+4 +: 4]);
                    busy_s       = 1'b0;
                    valid_s      = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    state_s      = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                valid_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {WIDTH{1'b0}};
            scratch_r  <= {BCD_W{1'b0}};
            last_r     <= {WIDTH{1'b0}};
            ones       <= 4'd0;
            tens       <= 4'd0;
            hundreds   <= 4'd0;
            tens_blank <= 1'b1;
            hund_blank <= 1'b1;
            busy       <= 1'b0;
            valid      <= 1'b1;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            scratch_r  <= scratch_s;
            last_r     <= last_s;
            ones       <= ones_s;
            tens       <= tens_s;
            hundreds   <= hundreds_s;
            tens_blank <= tens_blank_s;
            hund_blank <= hund_blank_s;
            busy       <= busy_s;
            valid      <= valid_s;
        end
    end

endmodule : score_bcd_converter

// File: tb/tb_score_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_converter
// Self-checking bench: a behavioural model (last captured value, remaining
// conversion edges, value currently displayed) is compared against the DUT on
// every falling edge, and directed scenarios pin literal expectations.
// -----------------------------------------------------------------------------
module tb_score_bcd_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] score_in;
    logic [3:0] ones, tens, hundreds;
    logic       tens_blank, hund_blank, busy, valid;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: value being/last converted, edges left, value on display
    int m_last  = 0;
    int m_left  = 0;
    int m_shown = 0;

    score_bcd_converter dut (
        .clk        (clk),
        .rst        (rst),
        .score_in   (score_in),
        .ones       (ones),
        .tens       (tens),
        .hundreds   (hundreds),
        .tens_blank (tens_blank),
        .hund_blank (hund_blank),
        .busy       (busy),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: a change seen while idle takes 9 edges to display
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last  <= 0;
            m_left  <= 0;
            m_shown <= 0;
        end else if (m_left == 0) begin
            if (int'(score_in) != m_last) begin
                m_last <= int'(score_in);
                m_left <= 8;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) m_shown <= m_last;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int eh, et, eo;
            bit eb, ev, etb, ehb;
            eh  = m_shown / 100;
            et  = (m_shown / 10) % 10;
            eo  = m_shown % 10;
            eb  = (m_left != 0);
            ev  = (m_left == 0);
            ehb = (eh == 0);
            etb = (eh == 0) && (et == 0);
            n_cmp++;
            if (int'(hundreds) != eh || int'(tens) != et || int'(ones) != eo ||
                busy != eb || valid != ev || tens_blank != etb || hund_blank != ehb) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got h/t/o=%0d/%0d/%0d tb=%b hb=%b busy=%b valid=%b, want %0d/%0d/%0d tb=%b hb=%b busy=%b valid=%b",
                         $time, hundreds, tens, ones, tens_blank, hund_blank, busy, valid,
                         eh, et, eo, etb, ehb, eb, ev);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, exp);
        end
    endtask

    task automatic check_digits(input string name, input int h, input int t, input int o);
        check({name, "_hundreds"}, int'(hundreds), h);
        check({name, "_tens"}, int'(tens), t);
        check({name, "_ones"}, int'(ones), o);
        check({name, "_valid"}, int'(valid), 1);
    endtask

    // Present a new score just after an edge
    task automatic apply(input int v);
        @(posedge clk);
        #2 score_in = 8'(v);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        score_in = 8'd0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;

        // Idle hold after reset
        repeat (10) @(posedge clk);
        #1;
        check_digits("idle", 0, 0, 0);
        check("idle_busy", int'(busy), 0);
        check("idle_tens_blank", int'(tens_blank), 1);
        check("idle_hund_blank", int'(hund_blank), 1);

        // Single conversion and latency
        apply(11);
        @(posedge clk); #1;
        check("lat_busy_e0", int'(busy), 1);
        check("lat_valid_e0", int'(valid), 0);
        repeat (7) @(posedge clk);
        #1;
        check("lat_valid_e7", int'(valid), 0);
        check("lat_ones_e7", int'(ones), 0);
        @(posedge clk); #1;
        check_digits("lat_e8", 0, 1, 1);
        check("lat_busy_e8", int'(busy), 0);
        check("lat_tens_blank", int'(tens_blank), 0);
        check("lat_hund_blank", int'(hund_blank), 1);

        // Full range
        apply(255);
        repeat (10) @(posedge clk);
        #1;
        check_digits("v255", 2, 5, 5);
        check("model_255", m_shown, 255);
        apply(100);
        repeat (10) @(posedge clk);
        #1;
        check_digits("v100", 1, 0, 0);
        check("v100_hund_blank", int'(hund_blank), 0);
        check("v100_tens_blank", int'(tens_blank), 0);
        apply(9);
        repeat (10) @(posedge clk);
        #1;
        check_digits("v9", 0, 0, 9);
        check("v9_tens_blank", int'(tens_blank), 1);
        check("v9_hund_blank", int'(hund_blank), 1);

        // Change mid-conversion: 7 then 12 sampled at E3
        apply(7);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2 score_in = 8'd12;
        repeat (6) @(posedge clk);
        #1;
        check_digits("mid_e8", 0, 0, 7);
        repeat (8) @(posedge clk);
        #1;
        check("mid_valid_e16", int'(valid), 0);
        check("mid_ones_e16", int'(ones), 7);
        @(posedge clk); #1;
        check_digits("mid_e17", 0, 1, 2);

        // Reset mid-conversion
        apply(200);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_digits("rst_mid", 0, 0, 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_hund_blank", int'(hund_blank), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check_digits("rst_restart", 2, 0, 0);
        check("model_200", m_shown, 200);

        // Randomized changes at random spacing, including mid-conversion ones
        for (int i = 0; i < 40; i++) begin
            apply(int'($urandom_range(0, 255)));
            repeat ($urandom_range(1, 15)) @(posedge clk);
        end
        repeat (20) @(posedge clk);

        // Scorekeeper sweep 0..11 then back to 0
        for (int s = 0; s <= 12; s++) begin
            int v;
            v = (s == 12) ? 0 : s;
            apply(v);
            repeat (11) @(posedge clk);
            #1;
            check_digits($sformatf("sweep%0d", s), v / 100, (v / 10) % 10, v % 10);
        end
        check("sweep_final_tens_blank", int'(tens_blank), 1);

        @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_score_bcd_converter
